// File: rtl/xlr8_uart_pkg.sv
// Shared types and helpers for the XLR8 UART receive path.
// Holds the receiver state encoding and the baud divisor calculation.
package xlr8_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/xlr8_uart_fifo.sv
// First-word-fall-through byte FIFO with occupancy count.
// The head entry is presented combinationally; o_data reads 0 while empty.
module xlr8_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xlr8_uart_rx_capture.sv
// 8N1 UART receiver fed from the AVR TXD pin, buffering bytes in a FWFT FIFO.
// Contains the line synchronizer, bit timer, receive FSM and sticky overflow flag.
module xlr8_uart_rx_capture
  import xlr8_uart_pkg::*;
#(
  parameter int CLK_HZ     = 16000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clock,
  input  logic                          RESET_N,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);
  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic [1:0]       r_sync;
  rx_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_busy;
  logic             r_overflow;
  logic             w_rxd_s;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  // Reset to the idle level so release never fakes a start edge.
  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], rxd};
  end
  assign w_rxd_s = r_sync[1];

  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_cnt   <= HALF_M1;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_rxd_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt     <= DIV_M1;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Line is LSB-first, so each new bit enters at the top.
            r_shift <= {w_rxd_s, r_shift[7:1]};
            r_cnt   <= DIV_M1;
            if (r_bit_idx == 3'd7) r_state   <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_rxd_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (w_rxd_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_push = (r_state == S_STOP) && (r_cnt == '0) && w_rxd_s;
  assign w_pop  = !w_empty && rx_ready;

  // A new drop takes priority over a simultaneous clear.
  always_ff @(posedge Clock or negedge RESET_N) begin
    if (!RESET_N)                        r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    else if (clr_overflow)               r_overflow <= 1'b0;
  end

  xlr8_uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (Clock),
    .rst_n  (RESET_N),
    .i_push (w_push),
    .i_data (r_shift),
    .i_pop  (w_pop),
    .o_data (rx_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(fifo_count)
  );

  assign rx_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign busy      = r_busy;

endmodule

// File: doc/xlr8_uart_rx_capture.md
# xlr8_uart_rx_capture

Synthesizable UART receiver that sits directly downstream of the XLR8 board's TXD pin and consumes the serial stream the AVR core produces. It synchronizes the line, deserializes 8N1 frames, and buffers received bytes in a small first-word-fall-through FIFO with a valid/ready read port. It serves as the board-level byte sink in the top-level testbench and as a reusable receive front end in the same design.

## Interface
Parameters:
- CLK_HZ, 16000000, core clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.

Ports:
- Clock  in  1  core clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset; single clock domain.
- rxd  in  1  serial line from DUT TXD; idle high; asynchronous to Clock.
- rx_data  out  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts head byte when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- clr_overflow  in  1  synchronous clear of overflow.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  receiver not in IDLE.

## Operation
- rxd passes through a 2-flop synchronizer (both flops reset to 1) to produce rxd_s; all logic uses rxd_s only.
- DIV = (CLK_HZ + BAUD/2) / BAUD, integer; HALF = DIV/2. Default: DIV=139, HALF=69.
- State machine:
  - IDLE: on rxd_s=0, load counter with HALF-1, go to START.
  - START: at counter=0, sample rxd_s; if 1 → IDLE (glitch rejected); if 0 → load DIV-1, clear bit index, go to DATA.
  - DATA: at counter=0, shift rxd_s into the MSB of the shift register (LSB-first line order); after bit index 7 → load DIV-1, go to STOP; otherwise reload DIV-1.
  - STOP: at counter=0, sample rxd_s. If 1 → push byte, go to IDLE. If 0 → pulse frame_err, discard byte, go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE.
- FIFO push on the STOP-success cycle. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set.
- Push and pop in the same cycle: both are performed and the count is unchanged, including when the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH. Count saturates at neither end, because the push/pop rules prevent it.
- clr_overflow clears overflow. If a clear and a new drop occur in the same cycle, the set wins.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overflow=0, fifo_count=0, busy=0, state=IDLE.
- Reset asserted mid-frame aborts the frame and empties the FIFO. After release, a line held low is treated as a new start edge.

## Timing
- Start-edge detection lags the rxd pin by 2 cycles (synchronizer).
- Data bit k is sampled HALF+(k+1)·DIV cycles after IDLE sees rxd_s=0. The stop bit is sampled at HALF+9·DIV.
- rx_valid rises 1 cycle after the stop-bit sample, i.e. the push is registered.
- rx_data is stable while rx_valid=1 and no pop occurs. After a pop, the next entry appears in the following cycle.
- frame_err is high for exactly one cycle, the cycle after the stop-bit sample.
- Back-to-back frames: because the receiver returns to IDLE at mid-stop-bit, a start bit immediately following is accepted.

## Structure
- Package xlr8_uart_pkg: state enum (IDLE, START, DATA, STOP, BREAK) and a constant function computing DIV from CLK_HZ and BAUD.
- Sub-module xlr8_uart_fifo: parameterized FWFT byte FIFO providing push, pop, full, empty and count. The top level holds the synchronizer, counter, FSM and overflow flag.

## Test plan
- Send 0x55 at 115200 baud, rx_ready=1 → exactly one rx_valid&rx_ready handshake with rx_data=0x55; frame_err=0.
- Send 0x00, 0xFF and 0xA3 back-to-back with no idle gap → three bytes in order, fifo_count peaking at 3 with rx_ready=0, then draining to 0.
- Drive a 40-cycle low pulse on idle rxd → no push, busy returns to 0, and rx_valid stays 0.
- Send 0x3C with the stop bit forced low, then return the line high → one frame_err pulse, no push, and the next frame 0x12 is received correctly.
- With rx_ready=0, send 17 bytes (0x00–0x10) → fifo_count=16 and overflow=1; the pops return 0x00–0x0F; pulsing clr_overflow then clears overflow.
- Assert RESET_N low during data bit 4 of a frame → all outputs return to their reset values; after release, the next full frame 0x7E is received intact.
